// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, condition codes, branch/cmov condition, E->M register.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valA,
  input  logic [W-1:0] e_valB,
  input  logic [W-1:0] e_valC,
  input  logic [3:0]   e_dstE,
  input  logic         stall,
  input  logic         bubble,
  input  logic         set_cc_en,
  output logic         m_valid,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [W-1:0] PLUS8  = {{(W-4){1'b0}}, 4'h8};
  localparam logic [W-1:0] MINUS8 = {{(W-4){1'b1}}, 4'h8};

  logic         r_valid, r_cnd, r_zf, r_sf, r_of;
  logic [3:0]   r_icode, r_dstE;
  logic [W-1:0] r_valE, r_valA;

  logic [W-1:0] w_alu_a, w_alu_b, w_valE;
  logic         w_of, w_cond, w_cnd, w_set_cc, w_lt;
  logic [3:0]   w_dstE;

  always_comb begin
    w_alu_a = '0;
    case (e_icode)
      4'h2, 4'h6:       w_alu_a = e_valA;
      4'h3, 4'h4, 4'h5: w_alu_a = e_valC;
      4'h8, 4'hA:       w_alu_a = MINUS8;
      4'h9, 4'hB:       w_alu_a = PLUS8;
      default:          w_alu_a = '0;
    endcase
    w_alu_b = '0;
    case (e_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = e_valB;
      default:                                  w_alu_b = '0;
    endcase
  end

  // Only OPq selects a non-add function; everything else is an address/pass-through add.
  always_comb begin
    w_valE = w_alu_b + w_alu_a;
    w_of   = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_valE[W-1] != w_alu_a[W-1]);
    if (e_icode == 4'h6) begin
      case (e_ifun)
        4'h0: ;
        4'h1: begin
          w_valE = w_alu_b - w_alu_a;
          w_of   = (w_alu_b[W-1] != w_alu_a[W-1]) && (w_valE[W-1] != w_alu_b[W-1]);
        end
        4'h2: begin
          w_valE = w_alu_b & w_alu_a;
          w_of   = 1'b0;
        end
        4'h3: begin
          w_valE = w_alu_b ^ w_alu_a;
          w_of   = 1'b0;
        end
        default: begin
          w_valE = '0;
          w_of   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_lt   = r_sf ^ r_of;
    w_cond = 1'b0;
    case (e_ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = w_lt | r_zf;
      4'h2:    w_cond = w_lt;
      4'h3:    w_cond = r_zf;
      4'h4:    w_cond = !r_zf;
      4'h5:    w_cond = !w_lt;
      4'h6:    w_cond = !w_lt && !r_zf;
      default: w_cond = 1'b0;
    endcase
    w_cnd    = (e_icode == 4'h2 || e_icode == 4'h7) ? w_cond : 1'b1;
    w_dstE   = (e_icode == 4'h2 && !w_cnd) ? RNONE : e_dstE;
    w_set_cc = e_valid && (e_icode == 4'h6) && (e_ifun <= 4'h3) && set_cc_en
               && !stall && !bubble;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_icode <= 4'h1;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_zf    <= 1'b1;
      r_sf    <= 1'b0;
      r_of    <= 1'b0;
    end else if (!stall) begin
      if (bubble || !e_valid) begin
        r_valid <= 1'b0;
        r_icode <= 4'h1;
        r_cnd   <= 1'b0;
        r_valE  <= '0;
        r_valA  <= '0;
        r_dstE  <= RNONE;
      end else begin
        r_valid <= 1'b1;
        r_icode <= e_icode;
        r_cnd   <= w_cnd;
        r_valE  <= w_valE;
        r_valA  <= e_valA;
        r_dstE  <= w_dstE;
      end
      if (w_set_cc) begin
        r_zf <= (w_valE == '0);
        r_sf <= w_valE[W-1];
        r_of <= w_of;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_icode = r_icode;
  assign m_cnd   = r_cnd;
  assign m_valE  = r_valE;
  assign m_valA  = r_valA;
  assign m_dstE  = r_dstE;
  assign cc_zf   = r_zf;
  assign cc_sf   = r_sf;
  assign cc_of   = r_of;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - vector table, corner sequences and randomized model comparison for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, e_valid, stall, bubble, set_cc_en;
  logic [3:0]  e_icode, e_ifun, e_dstE;
  logic [63:0] e_valA, e_valB, e_valC;
  logic        m_valid, m_cnd, cc_zf, cc_sf, cc_of;
  logic [3:0]  m_icode, m_dstE;
  logic [63:0] m_valE, m_valA;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_dstE(e_dstE),
    .stall(stall), .bubble(bubble), .set_cc_en(set_cc_en),
    .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE),
    .m_valA(m_valA), .m_dstE(m_dstE), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // reference state: what M and CC should hold
  logic        x_valid, x_cnd, x_zf, x_sf, x_of;
  logic [3:0]  x_icode, x_dstE;
  logic [63:0] x_valE, x_valA;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic take(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
    logic less;
    less = (sf != of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [63:0] r;
    logic signed [63:0] sa, sb, sr;
    logic ov, c;
    if (rst) begin
      x_valid = 0; x_icode = 4'h1; x_cnd = 0; x_valE = 0; x_valA = 0; x_dstE = 4'hF;
      x_zf = 1; x_sf = 0; x_of = 0;
      return;
    end
    if (stall) return;
    r = 0; ov = 0;
    sa = $signed(e_valA); sb = $signed(e_valB);
    case (e_icode)
      4'h6: case (e_ifun)
        4'd0: begin r = e_valB + e_valA; sr = $signed(r);
                ov = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0); end
        4'd1: begin r = e_valB - e_valA; sr = $signed(r);
                ov = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0); end
        4'd2: r = e_valB & e_valA;
        4'd3: r = e_valB ^ e_valA;
        default: r = 0;
      endcase
      4'h2:       r = e_valA;
      4'h3:       r = e_valC;
      4'h4, 4'h5: r = e_valB + e_valC;
      4'h8, 4'hA: r = e_valB - 64'd8;
      4'h9, 4'hB: r = e_valB + 64'd8;
      default:    r = 0;
    endcase
    c = (e_icode == 4'h2 || e_icode == 4'h7) ? take(e_ifun, x_zf, x_sf, x_of) : 1'b1;
    if (bubble || !e_valid) begin
      x_valid = 0; x_icode = 4'h1; x_cnd = 0; x_valE = 0; x_valA = 0; x_dstE = 4'hF;
    end else begin
      x_valid = 1; x_icode = e_icode; x_cnd = c; x_valE = r; x_valA = e_valA;
      x_dstE = (e_icode == 4'h2 && !c) ? 4'hF : e_dstE;
    end
    if (e_valid && e_icode == 4'h6 && e_ifun < 4 && set_cc_en && !bubble) begin
      x_zf = (r == 0); x_sf = r[63]; x_of = ov;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 64'(m_valid), 64'(x_valid));
    chk({tag, ".icode"}, 64'(m_icode), 64'(x_icode));
    chk({tag, ".cnd"},   64'(m_cnd),   64'(x_cnd));
    chk({tag, ".valE"},  m_valE,       x_valE);
    chk({tag, ".dstE"},  64'(m_dstE),  64'(x_dstE));
    chk({tag, ".cc"},    64'({cc_zf, cc_sf, cc_of}), 64'({x_zf, x_sf, x_of}));
    if (x_valid) chk({tag, ".valA"}, m_valA, x_valA);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] d);
    e_valid = v; e_icode = ic; e_ifun = fn; e_valA = a; e_valB = b; e_valC = c; e_dstE = d;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rval();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic        v;
    logic [3:0]  ic, fn;
    logic [63:0] a, b, c;
    logic [3:0]  d;
    logic        cc_en;
    logic        xv;
    logic [3:0]  xic;
    logic        xcnd;
    logic [63:0] xe;
    logic [3:0]  xd;
    logic [2:0]  xcc;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 4'h3, 1, 1, 4'h6, 1, 64'h8000_0000_0000_0000, 4'h3, 3'b011});
    vt.push_back('{1, 4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h3, 1, 1, 4'h6, 1, 64'd0, 4'h3, 3'b100});
    vt.push_back('{1, 4'h6, 4'h1, 64'd3, 64'd5, 0, 4'h3, 0, 1, 4'h6, 1, 64'd2, 4'h3, 3'b100});
    vt.push_back('{1, 4'h6, 4'h1, 64'd2, 64'd1, 0, 4'h3, 1, 1, 4'h6, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 3'b010});
    vt.push_back('{1, 4'h2, 4'h1, 64'h1234, 64'd9, 0, 4'h5, 1, 1, 4'h2, 1, 64'h1234, 4'h5, 3'b010});
    vt.push_back('{1, 4'h2, 4'h6, 64'h55, 64'd9, 0, 4'h5, 1, 1, 4'h2, 0, 64'h55, 4'hF, 3'b010});
    vt.push_back('{1, 4'hA, 4'h0, 64'd7, 64'h100, 0, 4'h4, 1, 1, 4'hA, 1, 64'hF8, 4'h4, 3'b010});
    vt.push_back('{1, 4'hB, 4'h0, 64'd7, 64'h100, 0, 4'h4, 1, 1, 4'hB, 1, 64'h108, 4'h4, 3'b010});
    vt.push_back('{1, 4'h7, 4'h2, 64'd1, 64'd1, 64'h40, 4'hF, 1, 1, 4'h7, 1, 64'd0, 4'hF, 3'b010});
    vt.push_back('{1, 4'h7, 4'h7, 64'd1, 64'd1, 64'h40, 4'hF, 1, 1, 4'h7, 0, 64'd0, 4'hF, 3'b010});
    vt.push_back('{1, 4'h6, 4'h4, 64'd1, 64'd2, 0, 4'h2, 1, 1, 4'h6, 1, 64'd0, 4'h2, 3'b010});
    vt.push_back('{1, 4'h6, 4'h2, 64'hF0, 64'h3C, 0, 4'h2, 1, 1, 4'h6, 1, 64'h30, 4'h2, 3'b000});
    vt.push_back('{1, 4'h6, 4'h3, 64'hFF, 64'hFF, 0, 4'h2, 1, 1, 4'h6, 1, 64'd0, 4'h2, 3'b100});
    vt.push_back('{1, 4'h3, 4'h0, 64'd1, 64'd999, 64'hABCD, 4'h6, 1, 1, 4'h3, 1, 64'hABCD, 4'h6, 3'b100});
    vt.push_back('{1, 4'h5, 4'h0, 64'd1, 64'h20, 64'h10, 4'h6, 1, 1, 4'h5, 1, 64'h30, 4'h6, 3'b100});
    vt.push_back('{0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h6, 1, 0, 4'h1, 0, 64'd0, 4'hF, 3'b100});

    rst = 1; stall = 0; bubble = 0; set_cc_en = 1;
    drive(1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd3, 4'h1);
    tick();
    chk("reset.valid", 64'(m_valid), 64'd0);
    chk("reset.icode", 64'(m_icode), 64'h1);
    chk("reset.dstE",  64'(m_dstE),  64'hF);
    chk("reset.cc",    64'({cc_zf, cc_sf, cc_of}), 64'b100);
    rst = 0;

    foreach (vt[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vt[i].v, vt[i].ic, vt[i].fn, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
      set_cc_en = vt[i].cc_en;
      tick();
      chk({t, ".valid"}, 64'(m_valid), 64'(vt[i].xv));
      chk({t, ".icode"}, 64'(m_icode), 64'(vt[i].xic));
      chk({t, ".cnd"},   64'(m_cnd),   64'(vt[i].xcnd));
      chk({t, ".valE"},  m_valE,       vt[i].xe);
      chk({t, ".dstE"},  64'(m_dstE),  64'(vt[i].xd));
      chk({t, ".cc"},    64'({cc_zf, cc_sf, cc_of}), 64'(vt[i].xcc));
      if (vt[i].xv) chk({t, ".valA"}, m_valA, vt[i].a);
    end
    set_cc_en = 1;

    // stall freezes M and CC; stall with bubble still freezes; then bubble alone empties M
    drive(1, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h7);
    tick();
    chk("preload.valE", m_valE, 64'd2);
    chk("preload.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
    drive(1, 4'h6, 4'h1, 64'd2, 64'd2, 0, 4'h8);
    stall = 1;
    tick();
    chk("stall1.valE", m_valE, 64'd2);
    chk("stall1.dstE", 64'(m_dstE), 64'h7);
    chk("stall1.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
    bubble = 1;
    tick();
    chk("stall2.valid", 64'(m_valid), 64'd1);
    chk("stall2.valE", m_valE, 64'd2);
    chk("stall2.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
    stall = 0;
    tick();
    chk("bubble.valid", 64'(m_valid), 64'd0);
    chk("bubble.icode", 64'(m_icode), 64'h1);
    chk("bubble.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
    bubble = 0;

    // reset mid-stream overrides stall and a pending CC write
    drive(1, 4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h2);
    tick();
    chk("pre_rst.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b010);
    rst = 1; stall = 1;
    tick();
    chk("mid_rst.valid", 64'(m_valid), 64'd0);
    chk("mid_rst.cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
    rst = 0; stall = 0;

    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      bubble    = ($urandom_range(0, 7) == 0);
      set_cc_en = ($urandom_range(0, 5) != 0);
      drive($urandom_range(0, 7) != 0,
            ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 7)), rval(), rval(), rval(), 4'($urandom_range(0, 15)));
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
